// File: rtl/execute_stage.sv
// EX stage of the in-order RV32I pipeline: ALU, branch/jump resolution, wrong-path squash,
// sticky halt and retired-instruction counter. Optional EXEC_MUL_EN adds the single-cycle MUL* group.
`ifndef ALU_NOP
`define ALU_NOP    6'd0
`define ALU_LUI    6'd1
`define ALU_AUIPC  6'd2
`define ALU_JAL    6'd3
`define ALU_JALR   6'd4
`define ALU_BEQ    6'd5
`define ALU_BNE    6'd6
`define ALU_BLT    6'd7
`define ALU_BGE    6'd8
`define ALU_BLTU   6'd9
`define ALU_BGEU   6'd10
`define ALU_LB     6'd11
`define ALU_LH     6'd12
`define ALU_LW     6'd13
`define ALU_LBU    6'd14
`define ALU_LHU    6'd15
`define ALU_SB     6'd16
`define ALU_SH     6'd17
`define ALU_SW     6'd18
`define ALU_ADD    6'd19
`define ALU_SUB    6'd20
`define ALU_SLT    6'd21
`define ALU_SLTU   6'd22
`define ALU_XOR    6'd23
`define ALU_OR     6'd24
`define ALU_AND    6'd25
`define ALU_SLL    6'd26
`define ALU_SRL    6'd27
`define ALU_SRA    6'd28
`define ALU_MUL    6'd29
`define ALU_MULH   6'd30
`define ALU_MULHSU 6'd31
`define ALU_MULHU  6'd32
`define OP_TYPE_NONE 2'd0
`define OP_TYPE_REG  2'd1
`define OP_TYPE_IMM  2'd2
`define OP_TYPE_PC   2'd3
`endif

module execute_stage #(
  parameter int FLUSH_SLOTS = 2,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rstd,
  input  logic [31:0]       DE_pc,
  input  logic [31:0]       DE_rs1_data,
  input  logic [31:0]       DE_rs2_data,
  input  logic [31:0]       DE_imm,
  input  logic [4:0]        DE_rd_addr,
  input  logic [5:0]        DE_alu_code,
  input  logic [1:0]        DE_alu_op1_type,
  input  logic [1:0]        DE_alu_op2_type,
  input  logic              DE_w_enable,
  input  logic              DE_is_store,
  input  logic              DE_is_load,
  input  logic              DE_is_halt,
  output logic [31:0]       EX_pc,
  output logic [31:0]       EX_alu_result,
  output logic [31:0]       EX_rs2_data,
  output logic [4:0]        EX_rd_addr,
  output logic [5:0]        EX_alu_code,
  output logic              EX_w_enable,
  output logic              EX_is_store,
  output logic              EX_is_load,
  output logic              EX_is_halt,
  output logic              br_taken,
  output logic [31:0]       br_target,
  output logic              halted,
  output logic [CNT_W-1:0]  retired_cnt
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t            state_q, state_d;
  logic [1:0]        squash_q, squash_d;
  logic [31:0]       pc_q, pc_d, res_q, res_d, rs2_q, rs2_d, tgt_q, tgt_d;
  logic [4:0]        rd_q, rd_d;
  logic [5:0]        code_q, code_d;
  logic              we_q, we_d, st_q, st_d, ld_q, ld_d, ht_q, ht_d, bt_q, bt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [31:0] op1, op2, alu, target;
  logic        is_branch, taken, squashed, mul_code, drop;
`ifdef EXEC_MUL_EN
  logic [63:0] prod_ss, prod_su, prod_uu;
`endif

  always_comb begin
    op1 = 32'd0;
    op2 = 32'd0;
    case (DE_alu_op1_type)
      `OP_TYPE_REG: op1 = DE_rs1_data;
      `OP_TYPE_PC:  op1 = DE_pc;
      default:      op1 = 32'd0;
    endcase
    case (DE_alu_op2_type)
      `OP_TYPE_REG: op2 = DE_rs2_data;
      `OP_TYPE_IMM: op2 = DE_imm;
      default:      op2 = 32'd0;
    endcase
`ifdef EXEC_MUL_EN
    prod_ss = {{32{op1[31]}}, op1} * {{32{op2[31]}}, op2};
    prod_su = {{32{op1[31]}}, op1} * {32'd0, op2};
    prod_uu = {32'd0, op1} * {32'd0, op2};
`endif
    alu       = 32'd0;
    target    = DE_pc + DE_imm;
    taken     = 1'b0;
    is_branch = 1'b0;
    mul_code  = 1'b0;
    case (DE_alu_code)
      `ALU_ADD:   alu = op1 + op2;
      `ALU_SUB:   alu = op1 - op2;
      `ALU_SLT:   alu = {31'd0, $signed(op1) < $signed(op2)};
      `ALU_SLTU:  alu = {31'd0, op1 < op2};
      `ALU_XOR:   alu = op1 ^ op2;
      `ALU_OR:    alu = op1 | op2;
      `ALU_AND:   alu = op1 & op2;
      `ALU_SLL:   alu = op1 << op2[4:0];
      `ALU_SRL:   alu = op1 >> op2[4:0];
      `ALU_SRA:   alu = $unsigned($signed(op1) >>> op2[4:0]);
      `ALU_LUI:   alu = DE_imm;
      `ALU_AUIPC: alu = DE_pc + DE_imm;
      `ALU_LB, `ALU_LH, `ALU_LW, `ALU_LBU, `ALU_LHU,
      `ALU_SB, `ALU_SH, `ALU_SW: alu = DE_rs1_data + DE_imm;
      `ALU_JAL: begin
        alu   = DE_pc + 32'd4;
        taken = 1'b1;
      end
      `ALU_JALR: begin
        alu    = DE_pc + 32'd4;
        taken  = 1'b1;
        target = (DE_rs1_data + DE_imm) & ~32'd1;
      end
      `ALU_BEQ:  begin is_branch = 1'b1; taken = DE_rs1_data == DE_rs2_data; end
      `ALU_BNE:  begin is_branch = 1'b1; taken = DE_rs1_data != DE_rs2_data; end
      `ALU_BLT:  begin is_branch = 1'b1; taken = $signed(DE_rs1_data) <  $signed(DE_rs2_data); end
      `ALU_BGE:  begin is_branch = 1'b1; taken = $signed(DE_rs1_data) >= $signed(DE_rs2_data); end
      `ALU_BLTU: begin is_branch = 1'b1; taken = DE_rs1_data <  DE_rs2_data; end
      `ALU_BGEU: begin is_branch = 1'b1; taken = DE_rs1_data >= DE_rs2_data; end
`ifdef EXEC_MUL_EN
      `ALU_MUL:    begin mul_code = 1'b1; alu = prod_uu[31:0]; end
      `ALU_MULH:   begin mul_code = 1'b1; alu = prod_ss[63:32]; end
      `ALU_MULHSU: begin mul_code = 1'b1; alu = prod_su[63:32]; end
      `ALU_MULHU:  begin mul_code = 1'b1; alu = prod_uu[63:32]; end
`else
      `ALU_MUL, `ALU_MULH, `ALU_MULHSU, `ALU_MULHU: mul_code = 1'b1;
`endif
      default: alu = 32'd0;
    endcase
  end

  always_comb begin
    squashed = (squash_q != 2'd0) || (state_q == HALTED);
`ifdef EXEC_MUL_EN
    drop = squashed;
`else
    drop = squashed || mul_code;
`endif
    state_d  = state_q;
    squash_d = (squash_q != 2'd0) ? squash_q - 2'd1 : 2'd0;
    pc_d = 32'd0; res_d = 32'd0; rs2_d = 32'd0; rd_d = 5'd0; code_d = `ALU_NOP;
    we_d = 1'b0; st_d = 1'b0; ld_d = 1'b0; ht_d = 1'b0;
    bt_d = 1'b0; tgt_d = 32'd0;
    cnt_d = cnt_q;
    if (!drop) begin
      pc_d   = DE_pc;
      res_d  = alu;
      rs2_d  = DE_rs2_data;
      rd_d   = DE_rd_addr;
      code_d = DE_alu_code;
      we_d   = DE_w_enable && !is_branch;
      st_d   = DE_is_store;
      ld_d   = DE_is_load;
      ht_d   = DE_is_halt;
      if (DE_alu_code != `ALU_NOP) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      if (DE_is_halt) state_d = HALTED;
    end
    // A taken transfer only redirects from the correct path.
    if (!squashed && taken) begin
      bt_d     = 1'b1;
      tgt_d    = target;
      squash_d = 2'(FLUSH_SLOTS);
    end
  end

  always_ff @(negedge clk) begin
    if (!rstd) begin
      state_q <= RUN;   squash_q <= 2'd0;
      pc_q <= 32'd0;    res_q <= 32'd0;  rs2_q <= 32'd0; rd_q <= 5'd0;
      code_q <= `ALU_NOP;
      we_q <= 1'b0; st_q <= 1'b0; ld_q <= 1'b0; ht_q <= 1'b0;
      bt_q <= 1'b0; tgt_q <= 32'd0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d; squash_q <= squash_d;
      pc_q <= pc_d;     res_q <= res_d;  rs2_q <= rs2_d; rd_q <= rd_d;
      code_q <= code_d;
      we_q <= we_d; st_q <= st_d; ld_q <= ld_d; ht_q <= ht_d;
      bt_q <= bt_d; tgt_q <= tgt_d;
      cnt_q <= cnt_d;
    end
  end

  assign EX_pc         = pc_q;
  assign EX_alu_result = res_q;
  assign EX_rs2_data   = rs2_q;
  assign EX_rd_addr    = rd_q;
  assign EX_alu_code   = code_q;
  assign EX_w_enable   = we_q;
  assign EX_is_store   = st_q;
  assign EX_is_load    = ld_q;
  assign EX_is_halt    = ht_q;
  assign br_taken      = bt_q;
  assign br_target     = tgt_q;
  assign halted        = (state_q == HALTED);
  assign retired_cnt   = cnt_q;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed scenarios plus randomized slots
// compared against a slot-level reference model.
module tb_execute_stage;
  localparam logic [5:0] NOP=0, LUI=1, AUIPC=2, JAL=3, JALR=4, BEQ=5, BNE=6, BLT=7, BGE=8,
    BLTU=9, BGEU=10, LB=11, LW=13, LHU=15, SB=16, SW=18, ADD=19, SUB=20, SLT=21, SLTU=22,
    XOR_=23, OR_=24, AND_=25, SLL=26, SRL=27, SRA=28, MUL=29, MULH=30, MULHSU=31, MULHU=32;
  localparam logic [1:0] T_NONE=0, T_REG=1, T_IMM=2, T_PC=3;
  localparam int FLUSH = 2;

  typedef struct {
    logic [5:0] code; logic [1:0] t1, t2;
    logic [31:0] pc, rs1, rs2, imm; logic [4:0] rd;
    logic we, st, ld, ht;
  } slot_t;

  logic clk = 0, rstd = 0;
  logic [31:0] DE_pc = 0, DE_rs1_data = 0, DE_rs2_data = 0, DE_imm = 0;
  logic [4:0]  DE_rd_addr = 0;
  logic [5:0]  DE_alu_code = 0;
  logic [1:0]  DE_alu_op1_type = 0, DE_alu_op2_type = 0;
  logic DE_w_enable = 0, DE_is_store = 0, DE_is_load = 0, DE_is_halt = 0;
  logic [31:0] EX_pc, EX_alu_result, EX_rs2_data, br_target;
  logic [4:0]  EX_rd_addr;
  logic [5:0]  EX_alu_code;
  logic EX_w_enable, EX_is_store, EX_is_load, EX_is_halt, br_taken, halted;
  logic [31:0] retired_cnt;

  int errors = 0, checks = 0;

  // model state and expected outputs
  int m_squash_left; bit m_halted; logic [31:0] m_cnt;
  logic [31:0] e_pc, e_res, e_rs2, e_tgt; logic [4:0] e_rd; logic [5:0] e_code;
  logic e_we, e_st, e_ld, e_ht, e_bt;

  execute_stage dut (
    .clk(clk), .rstd(rstd),
    .DE_pc(DE_pc), .DE_rs1_data(DE_rs1_data), .DE_rs2_data(DE_rs2_data), .DE_imm(DE_imm),
    .DE_rd_addr(DE_rd_addr), .DE_alu_code(DE_alu_code),
    .DE_alu_op1_type(DE_alu_op1_type), .DE_alu_op2_type(DE_alu_op2_type),
    .DE_w_enable(DE_w_enable), .DE_is_store(DE_is_store), .DE_is_load(DE_is_load),
    .DE_is_halt(DE_is_halt),
    .EX_pc(EX_pc), .EX_alu_result(EX_alu_result), .EX_rs2_data(EX_rs2_data),
    .EX_rd_addr(EX_rd_addr), .EX_alu_code(EX_alu_code), .EX_w_enable(EX_w_enable),
    .EX_is_store(EX_is_store), .EX_is_load(EX_is_load), .EX_is_halt(EX_is_halt),
    .br_taken(br_taken), .br_target(br_target), .halted(halted), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  function automatic slot_t mk(input logic [5:0] code, input logic [1:0] t1, input logic [1:0] t2,
                               input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic [31:0] imm, input logic [4:0] rd, input logic we,
                               input logic ht);
    slot_t s;
    s.code = code; s.t1 = t1; s.t2 = t2; s.pc = pc; s.rs1 = rs1; s.rs2 = rs2;
    s.imm = imm; s.rd = rd; s.we = we; s.st = 0; s.ld = 0; s.ht = ht;
    return s;
  endfunction

  function automatic bit mul_enabled();
`ifdef EXEC_MUL_EN
    return 1;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_squash_left = 0; m_halted = 0; m_cnt = 0;
    e_pc = 0; e_res = 0; e_rs2 = 0; e_tgt = 0; e_rd = 0; e_code = NOP;
    e_we = 0; e_st = 0; e_ld = 0; e_ht = 0; e_bt = 0;
  endtask

  // Reference behaviour of one slot, written from the instruction semantics.
  task automatic model_apply(input slot_t s);
    longint unsigned a, b, ua, ub; longint sa, sb;
    bit is_mul, is_br, is_jump, tk, skip;
    logic [31:0] res, tgt;
    int sh;
    a  = (s.t1 == T_REG) ? s.rs1 : (s.t1 == T_PC) ? s.pc : 0;
    b  = (s.t2 == T_REG) ? s.rs2 : (s.t2 == T_IMM) ? s.imm : 0;
    sa = longint'($signed(a[31:0])); sb = longint'($signed(b[31:0]));
    ua = a; ub = b; sh = int'(b[4:0]);
    is_mul  = s.code inside {MUL, MULH, MULHSU, MULHU};
    is_br   = s.code inside {BEQ, BNE, BLT, BGE, BLTU, BGEU};
    is_jump = s.code inside {JAL, JALR};
    tk = 0; res = 0; tgt = s.pc + s.imm;
    case (s.code)
      ADD: res = 32'(a + b);           SUB: res = 32'(a - b);
      SLT: res = (sa < sb) ? 1 : 0;    SLTU: res = (ua < ub) ? 1 : 0;
      XOR_: res = 32'(a ^ b);          OR_: res = 32'(a | b);   AND_: res = 32'(a & b);
      SLL: res = 32'(a << sh);         SRL: res = 32'(a >> sh); SRA: res = 32'(sa >>> sh);
      LUI: res = s.imm;                AUIPC: res = s.pc + s.imm;
      MUL: res = 32'(sa * sb);
      MULH: res = 32'((sa * sb) >>> 32);
      MULHSU: res = 32'(((longint'(sa) * 64'(ub))) >>> 32);
      MULHU: res = 32'((ua * ub) >> 32);
      JAL: begin res = s.pc + 4; tk = 1; end
      JALR: begin res = s.pc + 4; tk = 1; tgt = (s.rs1 + s.imm) & 32'hFFFF_FFFE; end
      BEQ:  tk = s.rs1 == s.rs2;  BNE: tk = s.rs1 != s.rs2;
      BLT:  tk = $signed(s.rs1) < $signed(s.rs2);  BGE: tk = $signed(s.rs1) >= $signed(s.rs2);
      BLTU: tk = s.rs1 < s.rs2;   BGEU: tk = s.rs1 >= s.rs2;
      default: if (s.code inside {[LB:SW]}) res = s.rs1 + s.imm;
    endcase
    if (m_squash_left > 0 || m_halted) begin
      if (m_squash_left > 0) m_squash_left--;
      skip = 1; tk = 0;
    end else skip = is_mul && !mul_enabled();
    e_bt = tk; e_tgt = tk ? tgt : 0;
    if (tk) m_squash_left = FLUSH;
    if (skip) begin
      e_pc = 0; e_res = 0; e_rs2 = 0; e_rd = 0; e_code = NOP;
      e_we = 0; e_st = 0; e_ld = 0; e_ht = 0;
    end else begin
      e_pc = s.pc; e_res = res; e_rs2 = s.rs2; e_rd = s.rd; e_code = s.code;
      e_we = s.we && !is_br; e_st = s.st; e_ld = s.ld; e_ht = s.ht;
      if (s.code != NOP) m_cnt = m_cnt + 1;
      if (s.ht) m_halted = 1;
    end
  endtask

  // Present a slot, advance through the negedge update, return at the sampling posedge.
  task automatic drive(input slot_t s);
    DE_pc = s.pc; DE_rs1_data = s.rs1; DE_rs2_data = s.rs2; DE_imm = s.imm;
    DE_rd_addr = s.rd; DE_alu_code = s.code; DE_alu_op1_type = s.t1; DE_alu_op2_type = s.t2;
    DE_w_enable = s.we; DE_is_store = s.st; DE_is_load = s.ld; DE_is_halt = s.ht;
    model_apply(s);
    @(posedge clk);
  endtask

  task automatic do_reset(input int n);
    rstd = 0;
    for (int i = 0; i < n; i++) begin
      DE_alu_code = ADD; DE_alu_op1_type = T_REG; DE_alu_op2_type = T_REG;
      DE_rs1_data = $urandom; DE_rs2_data = $urandom; DE_pc = $urandom;
      DE_w_enable = 1; DE_is_halt = 0;
      @(posedge clk);
    end
    rstd = 1;
    model_reset();
  endtask

  task automatic test_reset();
    drive(mk(ADD, T_REG, T_REG, 32'h10, 5, 6, 0, 3, 1, 0));
    drive(mk(JAL, T_NONE, T_NONE, 32'h14, 0, 0, 32'h40, 1, 1, 0));
    do_reset(2);
    checks++;
    if ({EX_pc, EX_alu_result, EX_rs2_data, EX_rd_addr, EX_w_enable, EX_is_store, EX_is_load,
         EX_is_halt, br_taken, br_target, halted, retired_cnt} !== '0 || EX_alu_code !== NOP) begin
      errors++;
      $display("FAIL reset: pc=%h res=%h code=%0d we=%b bt=%b tgt=%h halted=%b cnt=%0d required all zero, code=NOP",
               EX_pc, EX_alu_result, EX_alu_code, EX_w_enable, br_taken, br_target, halted, retired_cnt);
    end
  endtask

  task automatic test_alu();
    do_reset(1);
    drive(mk(ADD, T_REG, T_REG, 32'h20, 32'h7FFF_FFFF, 1, 0, 5, 1, 0));
    checks++;
    if (EX_alu_result !== 32'h8000_0000 || EX_w_enable !== 1'b1 || retired_cnt !== 32'd1) begin
      errors++;
      $display("FAIL add_wrap: res=%h we=%b cnt=%0d required res=80000000 we=1 cnt=1",
               EX_alu_result, EX_w_enable, retired_cnt);
    end
    drive(mk(SRA, T_REG, T_IMM, 32'h24, 32'h8000_0010, 0, 4, 6, 1, 0));
    checks++;
    if (EX_alu_result !== 32'hF800_0001) begin
      errors++; $display("FAIL sra: got %h required f8000001", EX_alu_result);
    end
    drive(mk(SLTU, T_REG, T_REG, 32'h28, 1, 32'hFFFF_FFFF, 0, 7, 1, 0));
    checks++;
    if (EX_alu_result !== 32'd1 || retired_cnt !== 32'd3) begin
      errors++; $display("FAIL sltu: res=%h cnt=%0d required res=1 cnt=3", EX_alu_result, retired_cnt);
    end
  endtask

  task automatic test_branch_flush();
    do_reset(1);
    drive(mk(BEQ, T_REG, T_REG, 32'h100, 9, 9, 32'h20, 0, 0, 0));
    checks++;
    if (br_taken !== 1'b1 || br_target !== 32'h120 || EX_w_enable !== 1'b0) begin
      errors++; $display("FAIL beq_taken: bt=%b tgt=%h we=%b required bt=1 tgt=120 we=0",
                         br_taken, br_target, EX_w_enable);
    end
    for (int i = 0; i < 2; i++) begin
      drive(mk(ADD, T_REG, T_REG, 32'h104 + 4*i, 1, 2, 0, 4, 1, 0));
      checks++;
      if (br_taken !== 1'b0 || EX_w_enable !== 1'b0 || EX_alu_code !== NOP || retired_cnt !== 32'd1) begin
        errors++; $display("FAIL flush_slot%0d: bt=%b we=%b code=%0d cnt=%0d required bt=0 we=0 code=0 cnt=1",
                           i, br_taken, EX_w_enable, EX_alu_code, retired_cnt);
      end
    end
    drive(mk(ADD, T_REG, T_REG, 32'h120, 3, 4, 0, 4, 1, 0));
    checks++;
    if (EX_alu_result !== 32'd7 || EX_w_enable !== 1'b1 || EX_pc !== 32'h120 || retired_cnt !== 32'd2) begin
      errors++; $display("FAIL after_flush: res=%h we=%b pc=%h cnt=%0d required res=7 we=1 pc=120 cnt=2",
                         EX_alu_result, EX_w_enable, EX_pc, retired_cnt);
    end
  endtask

  task automatic test_jalr();
    do_reset(1);
    drive(mk(JALR, T_REG, T_IMM, 32'h300, 32'h203, 0, 0, 1, 1, 0));
    checks++;
    if (br_taken !== 1'b1 || br_target !== 32'h202 || EX_alu_result !== 32'h304 || EX_w_enable !== 1'b1) begin
      errors++; $display("FAIL jalr: bt=%b tgt=%h res=%h we=%b required bt=1 tgt=202 res=304 we=1",
                         br_taken, br_target, EX_alu_result, EX_w_enable);
    end
    drive(mk(BEQ, T_REG, T_REG, 32'h304, 5, 5, 32'h80, 0, 0, 0));
    checks++;
    if (br_taken !== 1'b0 || EX_alu_code !== NOP) begin
      errors++; $display("FAIL beq_in_window: bt=%b code=%0d required bt=0 code=0", br_taken, EX_alu_code);
    end
    drive(mk(ADD, T_REG, T_REG, 32'h308, 1, 1, 0, 2, 1, 0));
    drive(mk(ADD, T_REG, T_REG, 32'h202, 1, 1, 0, 2, 1, 0));
    checks++;
    if (EX_w_enable !== 1'b1 || EX_alu_result !== 32'd2 || retired_cnt !== 32'd2) begin
      errors++; $display("FAIL jalr_resume: we=%b res=%h cnt=%0d required we=1 res=2 cnt=2",
                         EX_w_enable, EX_alu_result, retired_cnt);
    end
  endtask

  task automatic test_halt();
    do_reset(1);
    drive(mk(ADD, T_REG, T_REG, 32'h40, 1, 1, 0, 2, 1, 0));
    drive(mk(ADD, T_REG, T_REG, 32'h44, 0, 0, 0, 0, 0, 1));
    checks++;
    if (EX_is_halt !== 1'b1 || halted !== 1'b1 || retired_cnt !== 32'd2) begin
      errors++; $display("FAIL halt_slot: is_halt=%b halted=%b cnt=%0d required 1 1 2",
                         EX_is_halt, halted, retired_cnt);
    end
    for (int i = 0; i < 3; i++) drive(mk(ADD, T_REG, T_REG, 32'h48 + 4*i, 1, 2, 0, 3, 1, 0));
    checks++;
    if (EX_w_enable !== 1'b0 || EX_is_halt !== 1'b0 || halted !== 1'b1 || retired_cnt !== 32'd2) begin
      errors++; $display("FAIL halted_squash: we=%b is_halt=%b halted=%b cnt=%0d required 0 0 1 2",
                         EX_w_enable, EX_is_halt, halted, retired_cnt);
    end
    do_reset(1);
    checks++;
    if (halted !== 1'b0) begin
      errors++; $display("FAIL halt_reset: halted=%b required 0", halted);
    end
    drive(mk(ADD, T_REG, T_REG, 32'h60, 1, 2, 0, 3, 1, 0));
    checks++;
    if (EX_w_enable !== 1'b1 || EX_alu_result !== 32'd3 || retired_cnt !== 32'd1) begin
      errors++; $display("FAIL run_after_halt: we=%b res=%h cnt=%0d required 1 3 1",
                         EX_w_enable, EX_alu_result, retired_cnt);
    end
  endtask

  task automatic test_mul();
    do_reset(1);
    drive(mk(MUL, T_REG, T_REG, 32'h80, 32'hFFFF_FFFF, 2, 0, 4, 1, 0));
`ifdef EXEC_MUL_EN
    checks++;
    if (EX_alu_result !== 32'hFFFF_FFFE || EX_w_enable !== 1'b1 || retired_cnt !== 32'd1) begin
      errors++; $display("FAIL mul: res=%h we=%b cnt=%0d required fffffffe 1 1",
                         EX_alu_result, EX_w_enable, retired_cnt);
    end
    drive(mk(MULHU, T_REG, T_REG, 32'h84, 32'hFFFF_FFFF, 2, 0, 4, 1, 0));
    checks++;
    if (EX_alu_result !== 32'h0000_0001) begin
      errors++; $display("FAIL mulhu: res=%h required 00000001", EX_alu_result);
    end
`else
    checks++;
    if (EX_w_enable !== 1'b0 || EX_alu_code !== NOP || retired_cnt !== 32'd0) begin
      errors++; $display("FAIL mul_disabled: we=%b code=%0d cnt=%0d required 0 0 0",
                         EX_w_enable, EX_alu_code, retired_cnt);
    end
`endif
  endtask

  task automatic test_random();
    logic [5:0] codes [0:29];
    slot_t s;
    codes = '{NOP, LUI, AUIPC, JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU, LB, LW, LHU, SB, SW,
              ADD, SUB, SLT, SLTU, XOR_, OR_, AND_, SLL, SRL, SRA, MUL, MULH, MULHSU, MULHU};
    do_reset(1);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 120) == 0) do_reset(1);
      s.code = codes[$urandom_range(0, 29)];
      s.t1 = 2'($urandom_range(0, 3)); s.t2 = 2'($urandom_range(0, 3));
      s.pc = $urandom & 32'hFFFF_FFFC; s.rs1 = $urandom; s.imm = $urandom;
      s.rs2 = ($urandom_range(0, 1) == 1) ? s.rs1 : $urandom;
      if ($urandom_range(0, 3) == 0) s.rs2 = 32'($urandom_range(0, 40));
      s.rd = 5'($urandom); s.st = s.code inside {SB, SW}; s.ld = s.code inside {LB, LW, LHU};
      s.we = (s.code != NOP) && !s.st && $urandom_range(0, 7) != 0;
      s.ht = (s.code != NOP) && $urandom_range(0, 150) == 0;
      if (s.code == NOP) begin s.rd = 0; s.rs2 = 0; s.pc = 0; end
      drive(s);
      checks++;
      if ({EX_pc, EX_alu_result, EX_rs2_data, EX_rd_addr, EX_alu_code, EX_w_enable, EX_is_store,
           EX_is_load, EX_is_halt, br_taken, br_target, halted, retired_cnt} !==
          {e_pc, e_res, e_rs2, e_rd, e_code, e_we, e_st, e_ld, e_ht, e_bt, e_tgt, m_halted, m_cnt}) begin
        errors++;
        $display("FAIL random[%0d] code=%0d: got pc=%h res=%h rs2=%h rd=%0d code=%0d we=%b st=%b ld=%b ht=%b bt=%b tgt=%h hlt=%b cnt=%0d required pc=%h res=%h rs2=%h rd=%0d code=%0d we=%b st=%b ld=%b ht=%b bt=%b tgt=%h hlt=%b cnt=%0d",
                 n, s.code, EX_pc, EX_alu_result, EX_rs2_data, EX_rd_addr, EX_alu_code, EX_w_enable,
                 EX_is_store, EX_is_load, EX_is_halt, br_taken, br_target, halted, retired_cnt,
                 e_pc, e_res, e_rs2, e_rd, e_code, e_we, e_st, e_ld, e_ht, e_bt, e_tgt, m_halted, m_cnt);
      end
    end
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    do_reset(2);
    test_reset();
    test_alu();
    test_branch_flush();
    test_jalr();
    test_halt();
    test_mul();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- EX stage of the in-order RV32I pipeline.
- Consumes the DE_* bundle registered by decode, evaluates the ALU, resolves branches and jumps, and registers the EX_* bundle for the memory/writeback stages.
- Squashes wrong-path slots after a taken control transfer.
- Holds a sticky halt state and a retired-instruction counter.

Parameters:
- FLUSH_SLOTS, 2, number of DE slots squashed after a taken branch/jump (1..3).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  pipeline clock; stage registers update on negedge clk, like all stage registers.
- rstd  in  1  synchronous active-low reset, sampled on the same edge.
- DE_pc  in  32  PC of the decoded instruction.
- DE_rs1_data  in  32  rs1 operand.
- DE_rs2_data  in  32  rs2 operand, also store data.
- DE_imm  in  32  sign-extended immediate.
- DE_rd_addr  in  5  destination register.
- DE_alu_code  in  6  `ALU_* code from define.svh; `ALU_NOP marks a bubble.
- DE_alu_op1_type  in  2  `OP_TYPE_NONE/REG/IMM/PC.
- DE_alu_op2_type  in  2  same encoding as op1.
- DE_w_enable  in  1  register write-enable.
- DE_is_store  in  1  store flag.
- DE_is_load  in  1  load flag.
- DE_is_halt  in  1  halt flag.
- EX_pc  out  32  registered PC.
- EX_alu_result  out  32  ALU result, memory address, or link value (pc+4).
- EX_rs2_data  out  32  store data.
- EX_rd_addr  out  5  registered destination register.
- EX_alu_code  out  6  registered code; memory uses it for width and sign.
- EX_w_enable  out  1  registered write-enable.
- EX_is_store  out  1  registered store flag.
- EX_is_load  out  1  registered load flag.
- EX_is_halt  out  1  registered halt flag.
- br_taken  out  1  registered redirect strobe, one cycle wide.
- br_target  out  32  registered redirect PC.
- halted  out  1  sticky halt status.
- retired_cnt  out  CNT_W  count of non-squashed, non-bubble instructions.

Behaviour:
- Reset (rstd=0 at the clock edge):
  - all EX_* outputs 0, EX_alu_code=`ALU_NOP;
  - br_taken=0, br_target=0, halted=0, retired_cnt=0;
  - state=RUN, squash counter=0.
  - Reset mid-flush or while HALTED returns to RUN immediately.
- Operand select:
  - op1: REG→rs1, PC→DE_pc, NONE→0.
  - op2: REG→rs2, IMM→imm, NONE→0.
- ALU:
  - All arithmetic is 32-bit and wraps.
  - Shifts use op2[4:0]; SRA is arithmetic.
  - SLT is signed; SLTU is unsigned.
  - LUI: result = imm.
  - AUIPC: result = pc + imm.
  - Loads/stores: result = rs1 + imm.
- Branches BEQ/BNE/BLT/BGE/BLTU/BGEU:
  - compare rs1 vs rs2; taken → target = pc + imm.
  - Branches never write rd (EX_w_enable=0).
- JAL: target = pc + imm. JALR: target = (rs1 + imm) & ~1.
  - Both always taken; result = pc + 4.
- Latency: 1 cycle; every accepted slot appears on EX_* at the next update. No backpressure; one slot is accepted per cycle.
- Squash:
  - A slot is squashed if the squash counter is non-zero, or state is HALTED.
  - A squashed slot registers as a bubble: all flags 0, `ALU_NOP, data 0; br_taken=0; the counter is not incremented.
  - A taken control transfer loads the squash counter with FLUSH_SLOTS; it decrements once per slot.
  - A taken branch inside a squash window is itself squashed: no redirect, no reload of the counter.
- State machine:
  - RUN: DE_is_halt on a non-squashed slot → HALTED; that slot passes through with EX_is_halt=1, and halted=1 from the same update.
  - HALTED: sticky until reset; every input slot is squashed.
- retired_cnt:
  - increments by 1 per non-squashed slot with DE_alu_code != `ALU_NOP, including the halt slot;
  - wraps at 2^CNT_W.

Optional Feature:
- EXEC_MUL_EN defined:
  - `ALU_MUL/MULH/MULHSU/MULHU are single-cycle 32x32.
  - MUL returns the low 32 bits; the MULH* variants return the high 32 bits with the respective signedness.
- EXEC_MUL_EN not defined:
  - those codes register as bubbles: EX_w_enable=0, EX_alu_code=`ALU_NOP;
  - they are not counted in retired_cnt.

Test Plan:
- Reset held 2 cycles mid-stream → all outputs 0, EX_alu_code=`ALU_NOP, retired_cnt=0.
- ADD, rs1=0x7FFFFFFF, rs2=1, REG/REG → EX_alu_result=0x80000000, EX_w_enable=1, retired_cnt+1.
- SRA, rs1=0x80000010, imm=4 → 0xF8000001. SLTU, rs1=1, rs2=0xFFFFFFFF → 1.
- BEQ at pc=0x100, imm=0x20, equal operands → br_taken=1 for 1 cycle, br_target=0x120; next 2 slots (ADDs) are bubbles; 3rd slot executes.
- JALR rs1=0x203, imm=0, rd=1 → br_target=0x202, EX_alu_result=pc+4. BEQ inside its flush window → no redirect.
- Halt slot → EX_is_halt=1, halted=1. Following ADDs are bubbles and retired_cnt is frozen. Pulse rstd=0 → RUN.
- MUL 0xFFFFFFFF×2: with EXEC_MUL_EN → 0xFFFFFFFE. MULHU with EXEC_MUL_EN → 0x00000001. Without EXEC_MUL_EN → bubble, EX_w_enable=0.
